// File: rtl/bcd_entry_pkg.sv
// rtl/bcd_entry_pkg.sv - shared types, sizes and the reverse double-dabble step for bcd_entry
package bcd_entry_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int VALUE_W    = 14;
    localparam int ITER       = 14;
    localparam int BCD_W      = NUM_DIGITS * 4;
    localparam int WORK_W     = BCD_W + VALUE_W;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // One reverse double-dabble iteration: shift right, then pull every BCD nibble >= 8 down by 3
    function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] s;
        s = w >> 1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (s[VALUE_W + 4*d +: 4] >= 4'd8) begin
                s[VALUE_W + 4*d +: 4] = s[VALUE_W + 4*d +: 4] - 4'd3;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer, debounce counter and single press event for one active-low key
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; the last agreeing sample flips the state
    localparam int            CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          raw_down;
    logic          pressed;
    logic [CW-1:0] cnt;

    assign raw_down = ~sync_2;

    // Two-flop synchronizer; resets to the released (high) level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
        end
    end

    // Flip debounced state after DEBOUNCE_CYCLES consecutive disagreeing samples; pulse press on release->pressed
    always_ff @(posedge clk) begin
        if (reset) begin
            pressed <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (raw_down != pressed) begin
                if (cnt == LAST) begin
                    pressed <= raw_down;
                    press   <= raw_down;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/bcd_entry.sv
// rtl/bcd_entry.sv - keypad-style BCD digit entry with reverse double-dabble conversion to binary
module bcd_entry
    import bcd_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [3:0]  SW,
    input  logic [2:0]  KEY,
    output logic [15:0] bcd,
    output logic [13:0] value,
    output logic        valid,
    output logic        busy,
    output logic        err
);

    localparam bcd_digit_t MAX_DIGIT = bcd_digit_t'(9);

    logic [2:0]        key_press;
    logic              ev_enter;
    logic              ev_clear;
    logic              ev_convert;
    state_t            state;
    logic [WORK_W-1:0] work;
    logic [WORK_W-1:0] next_work;
    logic [3:0]        iter;

    for (genvar k = 0; k < 3; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk   (CLOCK_50),
            .reset (reset),
            .key_n (KEY[k]),
            .press (key_press[k])
        );
    end

    assign ev_enter   = key_press[0];
    assign ev_clear   = key_press[1];
    assign ev_convert = key_press[2];

    assign next_work = dabble_step(work);

    // Entry/clear in IDLE, then ITER conversion steps on a private copy of bcd, one DONE cycle to publish
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
            bcd   <= '0;
            value <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
            work  <= '0;
            iter  <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ev_clear) begin
                        bcd   <= '0;
                        value <= '0;
                        err   <= 1'b0;
                    end else if (ev_convert) begin
                        work  <= {bcd, {VALUE_W{1'b0}}};
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end else if (ev_enter) begin
                        if (SW <= MAX_DIGIT) begin
                            bcd <= {bcd[BCD_W-5:0], SW};
                            err <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    work <= next_work;
                    iter <= iter + 4'd1;
                    if (iter == 4'(ITER - 1)) begin
                        value <= next_work[VALUE_W-1:0];
                        valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd_entry.md
BCD_ENTRY -- requirements
Module: bcd_entry

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of stable-low clocks before a key counts as pressed (10 ms at 50 MHz).
REQ-002 The block SHALL have port CLOCK_50  in  1  system clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have port SW  in  4  digit value to enter (0-9 legal).
REQ-005 The block SHALL have port KEY  in  3  active-low buttons: KEY[0] enter digit, KEY[1] clear, KEY[2] convert.
REQ-006 The block SHALL have port bcd  out  16  entered digits; bcd[15:12] thousands ... bcd[3:0] units.
REQ-007 The block SHALL have port value  out  14  binary equivalent of bcd from the last conversion.
REQ-008 The block SHALL have port valid  out  1  one-cycle pulse when value is updated.
REQ-009 The block SHALL have port busy  out  1  high while a conversion is in progress.
REQ-010 The block SHALL have port err  out  1  sticky flag: last entry attempt had SW > 9.

Function
REQ-011 The block SHALL pass each KEY bit through a 2-flop synchronizer and then a debouncer that reports pressed after DEBOUNCE_CYCLES consecutive low samples and released after DEBOUNCE_CYCLES consecutive high samples.
REQ-012 The block SHALL generate exactly one press event per key, in the cycle the debounced state goes from released to pressed; holding a key SHALL produce no further events.
REQ-013 The block SHALL implement FSM states IDLE, CONV and DONE; transitions: IDLE->CONV on convert event, CONV->DONE after 14 iterations, DONE->IDLE unconditionally after 1 cycle.
REQ-014 In IDLE, an enter event with SW <= 9 SHALL shift bcd left one digit, insert SW as units, drop the thousands digit and clear err.
REQ-015 In IDLE, an enter event with SW > 9 SHALL set err and leave bcd unchanged.
REQ-016 In IDLE, a clear event SHALL set bcd, value and err to 0.
REQ-017 When press events coincide in IDLE, the block SHALL apply priority clear > convert > enter and act on the winning event only.
REQ-018 The block SHALL ignore all press events while in CONV or DONE.
REQ-019 The block SHALL convert with reverse double-dabble on a 30-bit working register loaded with {bcd, 14'b0}: each CONV cycle, shift right 1, then subtract 3 from every BCD nibble that is >= 8.
REQ-020 The bcd output SHALL remain unchanged during conversion; the working register is a separate copy.
REQ-021 For a convert event in cycle t, busy SHALL be high in cycles t+1..t+15, value SHALL update and valid SHALL pulse in cycle t+15, and the FSM SHALL return to IDLE in cycle t+16.
REQ-022 value SHALL hold its last result until the next DONE, clear or reset; the maximum result, 9999, fits in 14 bits with no overflow.

Reset
REQ-023 While reset is high at a clock edge, bcd, value, valid, busy and err SHALL be 0, the FSM SHALL be IDLE, and all debouncers SHALL be in the released state with counters at 0.
REQ-024 Reset during CONV or DONE SHALL abort the conversion; valid SHALL NOT assert for the aborted conversion.
REQ-025 A key still held when reset deasserts SHALL produce a press event only after DEBOUNCE_CYCLES low samples.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the constants NUM_DIGITS=4, VALUE_W=14 and ITER=14, and the BCD digit typedef.
REQ-027 Sub-module key_debounce (synchronizer + debounce counter + press-event output, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per KEY bit.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-028 Enter 1,2,3,4 then convert -> bcd=0x1234; busy high 15 cycles; valid pulses once at press+15; value=1234 (0x4D2).
REQ-029 Enter 9,9,9,9 then convert -> value=9999 (0x270F); enter 1,2,3,4,5 -> bcd=0x2345.
REQ-030 With bcd=0x0042, SW=0xA enter -> err=1, bcd=0x0042; then SW=7 enter -> err=0, bcd=0x0427.
REQ-031 KEY[0] low pulses of 1-3 cycles -> no change to bcd; KEY[0] held low 100 cycles -> exactly one digit entered.
REQ-032 Clear and convert pressed in the same cycle -> bcd=0, value=0, busy stays 0; clear pressed during CONV -> ignored, and a correct value appears at press+15.
REQ-033 Reset asserted in the 7th CONV cycle -> next cycle busy=0, value=0, bcd=0; valid stays 0 for 20 cycles after reset releases.
